// File: rtl/i2c_apb_regs.sv
// APB3 register file for i2c_core: control/status, interrupt and FIFO access.
// Define I2C_TIMING_REGS_EN to make the timing and debounce registers writable.
module i2c_apb_regs #(
  parameter logic [31:0] T_RST   = 32'd500,
  parameter logic [13:0] DEB_RST = 14'd10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [7:0]  paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        irq_o,
  output logic [7:0]  cr_o,
  input  logic [7:0]  cr_clr_i,
  input  logic [6:0]  cr_set_i,
  input  logic [7:0]  sr_i,
  input  logic [7:0]  irq_req_i,
  input  logic [4:0]  tx_fifo_ocy_i,
  input  logic [4:0]  rx_fifo_ocy_i,
  output logic        tx_fifo_wr_o,
  output logic [9:0]  tx_fifo_din_o,
  output logic        rx_fifo_rd_o,
  input  logic [7:0]  rx_fifo_dout_i,
  output logic [6:0]  slv_adr_o,
  output logic [4:0]  rx_fifo_pirq_o,
  output logic [13:0] debounce_cnt_o,
  output logic [31:0] tsusta_o,
  output logic [31:0] thdsta_o,
  output logic [31:0] tsusto_o,
  output logic [31:0] tsudat_o,
  output logic [31:0] thddat_o,
  output logic [31:0] tlow_o,
  output logic [31:0] thigh_o,
  output logic [31:0] tbuf_o
);

  localparam logic [5:0] AdrGie    = 6'h00;
  localparam logic [5:0] AdrIsr    = 6'h01;
  localparam logic [5:0] AdrIer    = 6'h02;
  localparam logic [5:0] AdrSoftr  = 6'h03;
  localparam logic [5:0] AdrCr     = 6'h04;
  localparam logic [5:0] AdrSr     = 6'h05;
  localparam logic [5:0] AdrTxf    = 6'h06;
  localparam logic [5:0] AdrRxf    = 6'h07;
  localparam logic [5:0] AdrAdr    = 6'h08;
  localparam logic [5:0] AdrTxOcy  = 6'h09;
  localparam logic [5:0] AdrRxOcy  = 6'h0A;
  localparam logic [5:0] AdrPirq   = 6'h0B;
  localparam logic [5:0] AdrDeb    = 6'h0C;
  localparam logic [5:0] AdrTim0   = 6'h0D;
  localparam logic [5:0] AdrTbuf   = 6'h14;
  localparam logic [31:0] SoftrKey = 32'h0000_000A;

  logic [5:0] adr;
  logic       access, wr_en, rd_en;
  logic       unmapped, tx_full, rx_empty;
  logic       softr_go, softr_q;
  logic       unused_paddr;

  logic [7:0] cr_q, cr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] ier_q;
  logic       gie_q;
  logic       irq_q;
  logic [6:0] slv_adr_q;
  logic [4:0] pirq_q;

  logic [31:0] tim [8];
  logic [13:0] deb;

  assign adr          = paddr_i[7:2];
  assign unused_paddr = ^paddr_i[1:0];
  assign access       = psel_i & penable_i;
  assign wr_en        = access & pwrite_i;
  assign rd_en        = access & ~pwrite_i;
  assign unmapped     = adr > AdrTbuf;
  assign tx_full      = tx_fifo_ocy_i >= 5'd16;
  assign rx_empty     = rx_fifo_ocy_i == 5'd0;
  assign softr_go     = wr_en & (adr == AdrSoftr) & (pwdata_i == SoftrKey);

  // FIFO strobes are suppressed while reset is asserted so an aborted access cannot push/pop.
  assign tx_fifo_wr_o  = wr_en & (adr == AdrTxf) & ~tx_full & ~rst_i;
  assign rx_fifo_rd_o  = rd_en & (adr == AdrRxf) & ~rx_empty & ~rst_i;
  assign tx_fifo_din_o = pwdata_i[9:0];

  assign pready_o = 1'b1;

  always_comb begin
    pslverr_o = 1'b0;
    if (access) begin
      if (unmapped) begin
        pslverr_o = 1'b1;
      end else if (pwrite_i) begin
        pslverr_o = ((adr == AdrTxf) & tx_full) |
                    ((adr == AdrSoftr) & (pwdata_i != SoftrKey));
      end else begin
        pslverr_o = (adr == AdrRxf) & rx_empty;
      end
    end
  end

  always_comb begin
    prdata_o = 32'h0;
    case (adr)
      AdrGie:   prdata_o = {gie_q, 31'h0};
      AdrIsr:   prdata_o = {24'h0, isr_q};
      AdrIer:   prdata_o = {24'h0, ier_q};
      AdrCr:    prdata_o = {24'h0, cr_q};
      AdrSr:    prdata_o = {24'h0, sr_i};
      AdrRxf:   prdata_o = rx_empty ? 32'h0 : {24'h0, rx_fifo_dout_i};
      AdrAdr:   prdata_o = {24'h0, slv_adr_q, 1'b0};
      AdrTxOcy: prdata_o = {27'h0, tx_fifo_ocy_i};
      AdrRxOcy: prdata_o = {27'h0, rx_fifo_ocy_i};
      AdrPirq:  prdata_o = {27'h0, pirq_q};
      AdrDeb:   prdata_o = {18'h0, deb};
      default: begin
        if (adr >= AdrTim0 && adr <= AdrTbuf) prdata_o = tim[3'(adr - AdrTim0)];
      end
    endcase
  end

  // The cycle after a soft reset cr[1] pulses high to flush the TX FIFO, then self-clears.
  always_comb begin
    cr_d = (cr_q | {1'b0, cr_set_i}) & ~cr_clr_i;
    if (softr_q) cr_d[1] = 1'b0;
    if (wr_en && adr == AdrCr) cr_d = pwdata_i[7:0];
    if (softr_go) cr_d = 8'h02;
  end

  always_comb begin
    isr_d = isr_q;
    if (wr_en && adr == AdrIsr) isr_d = isr_q & ~pwdata_i[7:0];
    isr_d = isr_d | irq_req_i;
    if (softr_go) isr_d = 8'h00;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cr_q      <= 8'h00;
      isr_q     <= 8'h00;
      ier_q     <= 8'h00;
      gie_q     <= 1'b0;
      irq_q     <= 1'b0;
      softr_q   <= 1'b0;
      slv_adr_q <= 7'h00;
      pirq_q    <= 5'h00;
    end else begin
      cr_q    <= cr_d;
      isr_q   <= isr_d;
      irq_q   <= gie_q & (|(isr_q & ier_q));
      softr_q <= softr_go;
      if (softr_go) begin
        ier_q <= 8'h00;
        gie_q <= 1'b0;
      end else if (wr_en) begin
        if (adr == AdrIer) ier_q <= pwdata_i[7:0];
        if (adr == AdrGie) gie_q <= pwdata_i[31];
      end
      if (wr_en && adr == AdrAdr)  slv_adr_q <= pwdata_i[7:1];
      if (wr_en && adr == AdrPirq) pirq_q    <= pwdata_i[4:0];
    end
  end

`ifdef I2C_TIMING_REGS_EN
  logic [31:0] tim_q [8];
  logic [13:0] deb_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) tim_q[i] <= T_RST;
      deb_q <= DEB_RST;
    end else if (wr_en) begin
      if (adr == AdrDeb) deb_q <= pwdata_i[13:0];
      for (int i = 0; i < 8; i++) begin
        if (adr == AdrTim0 + 6'(i)) tim_q[i] <= pwdata_i;
      end
    end
  end

  assign tim = tim_q;
  assign deb = deb_q;
`else
  always_comb begin
    for (int i = 0; i < 8; i++) tim[i] = T_RST;
  end
  assign deb = DEB_RST;
`endif

  assign cr_o           = cr_q;
  assign irq_o          = irq_q;
  assign slv_adr_o      = slv_adr_q;
  assign rx_fifo_pirq_o = pirq_q;
  assign debounce_cnt_o = deb;
  assign tsusta_o       = tim[0];
  assign thdsta_o       = tim[1];
  assign tsusto_o       = tim[2];
  assign tsudat_o       = tim[3];
  assign thddat_o       = tim[4];
  assign tlow_o         = tim[5];
  assign thigh_o        = tim[6];
  assign tbuf_o         = tim[7];

endmodule

// File: doc/i2c_apb_regs.md
# i2c_apb_regs

APB3 slave register file sitting directly upstream of `i2c_core`. It holds the control register `cr` and merges the core's per-bit set/clear requests into it. It exposes `sr`, the FIFO occupancies and the timing/address registers, and pushes TX FIFO writes / pops RX FIFO reads. It latches the core's `irq_req` levels into a W1C interrupt status register and drives one system interrupt line.

## Interface
- `T_RST`, 32'd500: reset value of all eight timing registers (tsusta…tbuf).
- `DEB_RST`, 14'd10: reset value of `debounce_cnt`.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `psel`, `penable`, `pwrite` in 1: APB3 control.
- `paddr` in 8: byte address; bits [1:0] ignored.
- `pwdata` in 32: APB write data.
- `prdata` out 32: APB read data.
- `pready` out 1: tied 1; zero wait states.
- `pslverr` out 1: error response.
- `irq` out 1: registered interrupt line.
- `cr` out 8: control register to the core.
- `cr_clr` in 8, `cr_set` in 7: per-bit clear/set requests from the core (`cr_set` maps to `cr[6:0]`).
- `sr` in 8, `irq_req` in 8: core status bits and interrupt levels.
- `tx_fifo_ocy` in 5, `rx_fifo_ocy` in 5: FIFO occupancies.
- `tx_fifo_wr` out 1, `tx_fifo_din` out 10: TX FIFO push.
- `rx_fifo_rd` out 1: RX FIFO pop.
- `rx_fifo_dout` in 8: show-ahead RX FIFO head.
- `slv_adr` out 7, `rx_fifo_pirq` out 5, `debounce_cnt` out 14: configuration outputs.
- `tsusta`, `thdsta`, `tsusto`, `tsudat`, `thddat`, `tlow`, `thigh`, `tbuf` out 32 each: timing configuration.

## Operation
- Access phase is `psel & penable`. Writes commit at the end of the access cycle.
- Address map, word offsets:
  - 0x00 GIE: bit 31, RW.
  - 0x04 ISR: [7:0], W1C.
  - 0x08 IER: [7:0], RW.
  - 0x0C SOFTR: WO.
  - 0x10 CR: [7:0], RW.
  - 0x14 SR: RO, `sr`.
  - 0x18 TX_FIFO: WO, [9:0].
  - 0x1C RX_FIFO: RO, [7:0].
  - 0x20 ADR: [7:1] holds `slv_adr`.
  - 0x24 TX_OCY: RO.
  - 0x28 RX_OCY: RO.
  - 0x2C RX_PIRQ: [4:0].
  - 0x30 DEBOUNCE: [13:0].
  - 0x34–0x50 timing registers, in port order tsusta…tbuf.
- Unused bits read as 0. Unmapped offsets read 0 with `pslverr`=1; writes to them are ignored with `pslverr`=1.
- CR update priority, highest first:
  1. APB write to CR overrides all eight bits.
  2. Otherwise `cr <= (cr | {1'b0,cr_set}) & ~cr_clr`; clear beats set on the same bit.
- ISR:
  - A bit sets in every cycle its `irq_req` bit is 1.
  - Writing 1 clears a bit; if set and clear coincide in the same cycle, set wins.
- `irq <= GIE & |(ISR & IER)`.
- TX_FIFO write:
  - If `tx_fifo_ocy` < 16: one-cycle `tx_fifo_wr` pulse in the access cycle, `tx_fifo_din = pwdata[9:0]`.
  - If `tx_fifo_ocy` == 16: no push, `pslverr`=1.
- RX_FIFO read:
  - If `rx_fifo_ocy` != 0: `prdata = rx_fifo_dout` combinationally and a one-cycle `rx_fifo_rd` pulse.
  - If `rx_fifo_ocy` == 0: no pop, `prdata` = 0, `pslverr`=1.
- Reads never have side effects except RX_FIFO.
- SOFTR:
  - Writing 0x0000000A clears CR, ISR, IER and GIE on the next edge.
  - `cr[1]` (txfifo_rst) is held 1 for exactly one cycle after the soft reset and then returns to 0. This flushes the TX FIFO.
  - Any other value is ignored with `pslverr`=1.
- Reset values:
  - `cr`, ISR, IER, GIE, `irq`, `slv_adr`, `rx_fifo_pirq`: 0.
  - `tx_fifo_wr`, `rx_fifo_rd`: 0.
  - Timing registers: `T_RST`. `debounce_cnt`: `DEB_RST`.

## Timing
- Zero wait states; `pready`=1 always.
- `prdata` and `pslverr` are combinational in the access cycle.
- Write-to-output latency is 1 cycle: a register value is visible on the core-facing port on the edge after the access cycle.
- `tx_fifo_wr` and `rx_fifo_rd` are combinational in the access cycle and never last longer than 1 cycle per access.
- `irq_req` → ISR is 1 cycle; ISR → `irq` is 1 more cycle, for a total of 2 cycles.
- `cr_set`/`cr_clr` → `cr` is 1 cycle.
- An asynchronous `rst` mid-transfer aborts the transfer. No FIFO strobe is emitted in the reset cycle.

## Configuration
- `I2C_TIMING_REGS_EN` defined:
  - 0x30–0x50 are RW as described.
- `I2C_TIMING_REGS_EN` not defined:
  - The timing outputs are constant `T_RST` and `debounce_cnt` is constant `DEB_RST`.
  - Offsets 0x30–0x50 read back those constants.
  - Writes to 0x30–0x50 are ignored with `pslverr`=0.
  - No flops are inferred for these registers.

## Test plan
- **Reset defaults:** assert `rst` → read 0x34 = 500, read 0x30 = 10, `cr` = 0, `irq` = 0.
- **CR merge:**
  - Write CR = 0x05, then pulse `cr_set[3]` and `cr_clr[2]` together → `cr` = 0x09 one cycle later.
  - Write CR = 0x01 in the same cycle as `cr_set[4]` → `cr` = 0x01.
- **Interrupt path:** GIE = 1<<31, IER = 0x01; pulse `irq_req[0]` for 1 cycle → `irq` = 1 two cycles later. Write ISR = 0x01 while `irq_req[0]`=1 → ISR bit stays 1.
- **TX FIFO:**
  - Write 0x1A5 to 0x18 with `tx_fifo_ocy`=3 → one `tx_fifo_wr` pulse, `tx_fifo_din` = 0x1A5.
  - Same write with `tx_fifo_ocy`=16 → no pulse, `pslverr`=1.
- **RX FIFO:**
  - Read 0x1C with `rx_fifo_ocy`=2, `rx_fifo_dout`=0x3C → `prdata` = 0x3C, one `rx_fifo_rd` pulse.
  - Read with `rx_fifo_ocy`=0 → `prdata` = 0, `pslverr`=1, no pulse.
- **Soft reset:**
  - Write 0x0A to 0x0C with CR = 0xFF → `cr` = 0x02 for one cycle, then 0x00.
  - Write 0x05 to 0x0C → `pslverr`=1, CR unchanged.
